// File: rtl/seq_adder.sv
// Digit-serial adder: DIGIT bits per clock over N = WIDTH/DIGIT RUN cycles, start/busy/done handshake.
// Optional subtract mode and signed-overflow flag enabled by defining SEQ_ADDER_SUB_EN.
module seq_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             i_w_clk,
    input  logic             i_w_reset,
    input  logic             i_w_start,
    input  logic [WIDTH-1:0] i_w_a,
    input  logic [WIDTH-1:0] i_w_b,
    input  logic             i_w_cin,
`ifdef SEQ_ADDER_SUB_EN
    input  logic             i_w_sub,
    output logic             o_w_ovf,
`endif
    output logic             o_w_busy,
    output logic             o_w_done,
    output logic [WIDTH:0]   o_w_s
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_s;

    logic [WIDTH-1:0]       w_b_in;
    logic                   w_cin_in;
    logic [DIGIT:0]         w_dsum_ext;
    logic [DIGIT-1:0]       w_dsum;
    logic                   w_cout;
    logic [WIDTH+DIGIT-1:0] w_acc_ext;
    logic [WIDTH-1:0]       w_acc_next;
    logic                   w_last;

`ifdef SEQ_ADDER_SUB_EN
    logic r_amsb, r_bmsb, r_ovf;
    // Subtraction is A + ~B + 1; the operand MSBs are kept for the overflow test.
    assign w_b_in   = i_w_sub ? ~i_w_b : i_w_b;
    assign w_cin_in = i_w_sub ? 1'b1 : i_w_cin;
    assign o_w_ovf  = r_ovf;
`else
    assign w_b_in   = i_w_b;
    assign w_cin_in = i_w_cin;
`endif

    assign w_dsum_ext = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    assign w_dsum     = w_dsum_ext[DIGIT-1:0];
    assign w_cout     = w_dsum_ext[DIGIT];
    // New digit enters at the top; after N shifts the first digit sits at bit 0.
    assign w_acc_ext  = {w_dsum, r_acc};
    assign w_acc_next = w_acc_ext[WIDTH+DIGIT-1:DIGIT];
    assign w_last     = (r_cnt == CW'(N - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_w_start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
`ifdef SEQ_ADDER_SUB_EN
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (i_w_start) begin
                    r_a     <= i_w_a;
                    r_b     <= w_b_in;
                    r_carry <= w_cin_in;
                    r_acc   <= '0;
                    r_cnt   <= '0;
`ifdef SEQ_ADDER_SUB_EN
                    r_amsb  <= i_w_a[WIDTH-1];
                    r_bmsb  <= w_b_in[WIDTH-1];
`endif
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_cout;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_s <= {w_cout, w_acc_next};
`ifdef SEQ_ADDER_SUB_EN
                        r_ovf <= (r_amsb == r_bmsb) && (w_dsum[DIGIT-1] != r_amsb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_w_busy = (r_state != S_IDLE);
    assign o_w_done = (r_state == S_DONE);
    assign o_w_s    = r_s;
endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder: three instances (4/1, 4/2, 8/8) driven from a vector table
// plus hand-written sequences for restart-ignore, async reset and back-to-back operation.
module tb_seq_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       st0, st1, st2, ci0, ci1, ci2;
    logic [3:0] a0, b0, a1, b1;
    logic [7:0] a2, b2;
    logic       busy0, busy1, busy2, done0, done1, done2;
    logic [4:0] s0, s1;
    logic [8:0] s2;
`ifdef SEQ_ADDER_SUB_EN
    logic       sb0, sb1, sb2, ov0, ov1, ov2;
`endif

    seq_adder #(.WIDTH(4), .DIGIT(1)) u0 (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_start(st0), .i_w_a(a0), .i_w_b(b0), .i_w_cin(ci0),
`ifdef SEQ_ADDER_SUB_EN
        .i_w_sub(sb0), .o_w_ovf(ov0),
`endif
        .o_w_busy(busy0), .o_w_done(done0), .o_w_s(s0));
    seq_adder #(.WIDTH(4), .DIGIT(2)) u1 (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_start(st1), .i_w_a(a1), .i_w_b(b1), .i_w_cin(ci1),
`ifdef SEQ_ADDER_SUB_EN
        .i_w_sub(sb1), .o_w_ovf(ov1),
`endif
        .o_w_busy(busy1), .o_w_done(done1), .o_w_s(s1));
    seq_adder #(.WIDTH(8), .DIGIT(8)) u2 (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_start(st2), .i_w_a(a2), .i_w_b(b2), .i_w_cin(ci2),
`ifdef SEQ_ADDER_SUB_EN
        .i_w_sub(sb2), .o_w_ovf(ov2),
`endif
        .o_w_busy(busy2), .o_w_done(done2), .o_w_s(s2));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         k;
        logic [7:0] a, b;
        logic       cin, sub;
        logic [8:0] s;
        logic       ovf;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int k, input logic st, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub);
        case (k)
            0: begin st0 = st; a0 = a[3:0]; b0 = b[3:0]; ci0 = cin; end
            1: begin st1 = st; a1 = a[3:0]; b1 = b[3:0]; ci1 = cin; end
            default: begin st2 = st; a2 = a; b2 = b; ci2 = cin; end
        endcase
`ifdef SEQ_ADDER_SUB_EN
        case (k)
            0: sb0 = sub;
            1: sb1 = sub;
            default: sb2 = sub;
        endcase
`else
        if (sub) $display("note: subtract vector issued without SEQ_ADDER_SUB_EN");
`endif
    endtask

    function automatic logic get_busy(input int k);
        return (k == 0) ? busy0 : (k == 1) ? busy1 : busy2;
    endfunction
    function automatic logic get_done(input int k);
        return (k == 0) ? done0 : (k == 1) ? done1 : done2;
    endfunction
    function automatic logic [8:0] get_s(input int k);
        return (k == 0) ? {4'b0, s0} : (k == 1) ? {4'b0, s1} : s2;
    endfunction
`ifdef SEQ_ADDER_SUB_EN
    function automatic logic get_ovf(input int k);
        return (k == 0) ? ov0 : (k == 1) ? ov1 : ov2;
    endfunction
`endif

    // One start pulse; lat counts edges after the accept edge until done is seen (bounded).
    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, output logic [8:0] s, output logic ovf, output int lat);
        @(negedge clk);
        set_in(k, 1'b1, a, b, cin, sub);
        @(negedge clk);
        set_in(k, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("busy_after_accept", 32'(get_busy(k)), 32'd1);
        lat = 0;
        while (!get_done(k) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        s = get_s(k);
        ovf = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
        ovf = get_ovf(k);
`endif
        @(negedge clk);
        chk("done_one_cycle", 32'(get_done(k)), 32'd0);
        chk("s_holds", 32'(get_s(k)), 32'(s));
    endtask

    vec_t vec[12];
    int   nvec;

    initial begin
        logic [8:0] rs;
        logic       rov;
        int         lat;
        int         npulse, first_i, second_i;

        st0 = 0; st1 = 0; st2 = 0; ci0 = 0; ci1 = 0; ci2 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; a2 = 0; b2 = 0;
`ifdef SEQ_ADDER_SUB_EN
        sb0 = 0; sb1 = 0; sb2 = 0;
`endif
        vec[0] = '{0, 8'd9,   8'd7,   1'b0, 1'b0, 9'd16,  1'b0, 4};
        vec[1] = '{0, 8'd15,  8'd15,  1'b1, 1'b0, 9'd31,  1'b0, 4};
        vec[2] = '{0, 8'd4,   8'd4,   1'b0, 1'b0, 9'd8,   1'b1, 4};
        vec[3] = '{1, 8'd0,   8'd0,   1'b0, 1'b0, 9'd0,   1'b0, 2};
        vec[4] = '{1, 8'd15,  8'd1,   1'b0, 1'b0, 9'd16,  1'b0, 2};
        vec[5] = '{1, 8'd6,   8'd5,   1'b1, 1'b0, 9'd12,  1'b1, 2};
        vec[6] = '{2, 8'd255, 8'd1,   1'b0, 1'b0, 9'd256, 1'b0, 1};
        vec[7] = '{2, 8'd255, 8'd255, 1'b1, 1'b0, 9'd511, 1'b0, 1};
        vec[8] = '{2, 8'd127, 8'd1,   1'b0, 1'b0, 9'd128, 1'b1, 1};
        nvec = 9;
`ifdef SEQ_ADDER_SUB_EN
        vec[9]  = '{1, 8'd3, 8'd5, 1'b1, 1'b1, 9'b0_1110, 1'b0, 2};
        vec[10] = '{1, 8'd7, 8'd8, 1'b0, 1'b1, 9'b0_1111, 1'b1, 2};
        vec[11] = '{1, 8'd5, 8'd3, 1'b0, 1'b1, 9'b1_0010, 1'b0, 2};
        nvec = 12;
`endif

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_busy", 32'(get_busy(k)), 32'd0);
            chk("reset_done", 32'(get_done(k)), 32'd0);
            chk("reset_s",    32'(get_s(k)),    32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            run_op(vec[i].k, vec[i].a, vec[i].b, vec[i].cin, vec[i].sub, rs, rov, lat);
            chk($sformatf("vec%0d_s", i),   32'(rs), 32'(vec[i].s));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vec[i].lat));
`ifdef SEQ_ADDER_SUB_EN
            chk($sformatf("vec%0d_ovf", i), 32'(rov), 32'(vec[i].ovf));
`endif
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    run_op(1, 8'(a), 8'(b), 1'(c), 1'b0, rs, rov, lat);
                    chk($sformatf("exh_%0d_%0d_%0d", a, b, c), 32'(rs), 32'(a + b + c));
                end

        // Second start mid-RUN must not disturb the first operation.
        @(negedge clk);
        set_in(0, 1'b1, 8'd3, 8'd2, 1'b0, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        set_in(0, 1'b1, 8'd15, 8'd15, 1'b1, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        npulse = 0;
        rs = '0;
        for (int i = 0; i < 10; i++) begin
            if (done0) begin npulse++; rs = get_s(0); end
            @(negedge clk);
        end
        chk("restart_pulses", 32'(npulse), 32'd1);
        chk("restart_s",      32'(rs),     32'd5);

        // Asynchronous reset between edges while running.
        set_in(0, 1'b1, 8'd9, 8'd7, 1'b0, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy0), 32'd0);
        chk("async_rst_done", 32'(done0), 32'd0);
        chk("async_rst_s",    32'(s0),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 8'd15, 8'd15, 1'b1, 1'b0, rs, rov, lat);
        chk("post_rst_s",   32'(rs),  32'd31);
        chk("post_rst_lat", 32'(lat), 32'd4);

        // Start held high on the single-digit instance: one result every 3 clocks.
        @(negedge clk);
        set_in(2, 1'b1, 8'd255, 8'd1, 1'b0, 1'b0);
        npulse = 0; first_i = -1; second_i = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done2) begin
                if (npulse == 0) first_i = i;
                if (npulse == 1) second_i = i;
                npulse++;
                chk("b2b_s", 32'(s2), 32'd256);
            end
        end
        set_in(2, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        chk("b2b_pulses",  32'(npulse),              32'd4);
        chk("b2b_first",   32'(first_i),             32'd1);
        chk("b2b_spacing", 32'(second_i - first_i),  32'd3);
        repeat (4) @(negedge clk);
        chk("b2b_idle", 32'(busy2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
